dmg_cart_mbc1: RTL and testbench

MBC1-style cartridge mapper between the dmg_main CPU bus and the cartridge ROM (cart_prom) and the optional cart RAM.
- Decodes CPU writes to 0000-7FFF into bank, RAM-enable and mode registers.
- Translates CPU reads into banked ROM/RAM addresses.
- Returns read data with fixed 2-cycle latency, matching the synchronous 1-cycle PROM.

---
 rtl/dmg_cart_mbc1_pkg.sv | 45 ++++
 rtl/dmg_cart_mbc1_if.sv | 20 ++
 rtl/dmg_cart_mbc1_regs.sv | 58 +++++
 rtl/dmg_cart_mbc1.sv | 144 ++++++++++++++
 tb/tb_dmg_cart_mbc1.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmg_cart_mbc1_pkg.sv
// Shared types and constants for the MBC1 cartridge mapper.
package dmg_cart_pkg;

    // Where a CPU read is served from, carried down the read pipeline.
    typedef enum logic [1:0] {
        REG_ROM      = 2'd0,
        REG_RAM      = 2'd1,
        REG_RAM_OFF  = 2'd2,
        REG_UNMAPPED = 2'd3
    } region_t;

    // CPU address windows, matched as (addr & MASK) == BASE.
    localparam logic [15:0] ROM_BASE      = 16'h0000;
    localparam logic [15:0] ROM_MASK      = 16'h8000;
    localparam logic [15:0] ROM_BANK_BASE = 16'h4000;
    localparam logic [15:0] ROM_BANK_MASK = 16'hC000;
    localparam logic [15:0] RAM_BASE      = 16'hA000;
    localparam logic [15:0] RAM_MASK      = 16'hE000;

    // Low nibble that unlocks cart RAM.
    localparam logic [3:0] RAMG_KEY = 4'hA;

    // Bank 0 can never be selected in the switchable window.
    localparam logic [4:0] BANK_LO_RESET = 5'd1;

    // Control register select, taken from cpu_addr[14:13].
    localparam logic [1:0] SEL_RAMG    = 2'd0;
    localparam logic [1:0] SEL_BANK_LO = 2'd1;
    localparam logic [1:0] SEL_BANK_HI = 2'd2;
    localparam logic [1:0] SEL_MODE    = 2'd3;

    // Classify a CPU address into the region its read data comes from.
    function automatic region_t decode_region(input logic [15:0] addr, input logic ram_on);
        region_t r;
        if ((addr & ROM_MASK) == ROM_BASE) begin
            r = REG_ROM;
        end else if ((addr & RAM_MASK) == RAM_BASE) begin
            r = ram_on ? REG_RAM : REG_RAM_OFF;
        end else begin
            r = REG_UNMAPPED;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmg_cart_mbc1_if.sv
// CPU-side bus of the cartridge mapper: one read or write per cycle,
// read data returned later with a one-cycle valid pulse.
interface dmg_cart_mbc1_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;

    modport master (
        output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        input  cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        output cpu_rdata, cpu_rvalid
    );
endinterface

// File: rtl/dmg_cart_mbc1_regs.sv
// MBC1 control registers: RAM enable, low/high bank and banking mode.
// Written by CPU stores to 0000-7FFF; a zero low bank is stored as 1.
import dmg_cart_pkg::*;

module dmg_mbc1_regs (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] sel,
    input  logic [4:0] wdata,
    output logic [4:0] bank_lo,
    output logic [1:0] bank_hi,
    output logic       mode,
    output logic       ram_en
);

    logic [4:0] bank_lo_q, bank_lo_d;
    logic [1:0] bank_hi_q, bank_hi_d;
    logic       mode_q, mode_d;
    logic       ram_en_q, ram_en_d;

    // Decode the register select and compute the next register values.
    always_comb begin
        bank_lo_d = bank_lo_q;
        bank_hi_d = bank_hi_q;
        mode_d    = mode_q;
        ram_en_d  = ram_en_q;
        if (wr_en) begin
            case (sel)
                SEL_RAMG:    ram_en_d  = (wdata[3:0] == RAMG_KEY);
                SEL_BANK_LO: bank_lo_d = (wdata == 5'd0) ? BANK_LO_RESET : wdata;
                SEL_BANK_HI: bank_hi_d = wdata[1:0];
                default:     mode_d    = wdata[0];
            endcase
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_lo_q <= BANK_LO_RESET;
            bank_hi_q <= 2'd0;
            mode_q    <= 1'b0;
            ram_en_q  <= 1'b0;
        end else begin
            bank_lo_q <= bank_lo_d;
            bank_hi_q <= bank_hi_d;
            mode_q    <= mode_d;
            ram_en_q  <= ram_en_d;
        end
    end

    assign bank_lo = bank_lo_q;
    assign bank_hi = bank_hi_q;
    assign mode    = mode_q;
    assign ram_en  = ram_en_q;

endmodule

// File: rtl/dmg_cart_mbc1.sv
// MBC1 cartridge mapper: decodes CPU stores into control registers,
// maps CPU reads onto banked ROM / cart RAM addresses and returns the
// data two cycles after the request.
// Optional cart RAM path: define DMG_CART_MBC1_RAM_EN to enable it;
// without it the RAM outputs stay 0 and A000-BFFF reads return 8'hFF.
import dmg_cart_pkg::*;

module dmg_cart_mbc1 #(
    parameter int ROM_ADDR_W = 15,
    parameter int RAM_ADDR_W = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    dmg_cart_mbc1_if.slave        cpu,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_we,
    input  logic [7:0]            ram_data
);

`ifdef DMG_CART_MBC1_RAM_EN
    localparam bit RAM_PATH_EN = 1'b1;
`else
    localparam bit RAM_PATH_EN = 1'b0;
`endif

    logic [4:0] bank_lo;
    logic [1:0] bank_hi;
    logic       mode;
    logic       ram_en;
    logic       reg_wr;

    assign reg_wr = cpu.cpu_wr && ((cpu.cpu_addr & ROM_MASK) == ROM_BASE);

    dmg_mbc1_regs u_regs (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (reg_wr),
        .sel     (cpu.cpu_addr[14:13]),
        .wdata   (cpu.cpu_wdata[4:0]),
        .bank_lo (bank_lo),
        .bank_hi (bank_hi),
        .mode    (mode),
        .ram_en  (ram_en)
    );

    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_wdata_q, ram_wdata_d;
    logic                  ram_we_q, ram_we_d;
    logic                  s1_valid_q, s1_valid_d;
    region_t               tag1_q, tag1_d;
    logic                  rvalid_q, rvalid_d;
    region_t               tag2_q, tag2_d;

    logic                  rd_accept;
    logic                  in_ram_win;
    region_t               region;
    logic [20:0]           rom_full;
    logic [14:0]           ram_full;
    logic [7:0]            rdata;

    // Map the current request with the bank state of this cycle and compute the pipeline's next state.
    always_comb begin
        rd_accept  = cpu.cpu_rd && !cpu.cpu_wr;
        in_ram_win = ((cpu.cpu_addr & RAM_MASK) == RAM_BASE);
        region     = decode_region(cpu.cpu_addr, ram_en && RAM_PATH_EN);

        if ((cpu.cpu_addr & ROM_BANK_MASK) == ROM_BANK_BASE) begin
            rom_full = {bank_hi, bank_lo, cpu.cpu_addr[13:0]};
        end else begin
            rom_full = {(mode ? bank_hi : 2'b00), 5'b0, cpu.cpu_addr[13:0]};
        end
        ram_full = {(mode ? bank_hi : 2'b00), cpu.cpu_addr[12:0]};

        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        s1_valid_d  = rd_accept;
        tag1_d      = tag1_q;

        if (rd_accept) begin
            tag1_d = region;
            if (region == REG_ROM) begin
                rom_addr_d = ROM_ADDR_W'(rom_full);
            end
            if (in_ram_win && RAM_PATH_EN) begin
                ram_addr_d = RAM_ADDR_W'(ram_full);
            end
        end

        if (cpu.cpu_wr && in_ram_win && ram_en && RAM_PATH_EN) begin
            ram_addr_d  = RAM_ADDR_W'(ram_full);
            ram_wdata_d = cpu.cpu_wdata;
            ram_we_d    = 1'b1;
        end

        rvalid_d = s1_valid_q;
        tag2_d   = s1_valid_q ? tag1_q : tag2_q;
    end

    // Pipeline registers; reset also discards any read in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            tag1_q      <= REG_UNMAPPED;
            rvalid_q    <= 1'b0;
            tag2_q      <= REG_UNMAPPED;
        end else begin
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            s1_valid_q  <= s1_valid_d;
            tag1_q      <= tag1_d;
            rvalid_q    <= rvalid_d;
            tag2_q      <= tag2_d;
        end
    end

    // The memories register the address internally, so their output is steered by the stage-2 tag.
    always_comb begin
        case (tag2_q)
            REG_ROM: rdata = rom_data;
            REG_RAM: rdata = ram_data;
            default: rdata = 8'hFF;
        endcase
    end

    assign rom_addr       = rom_addr_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ram_we         = ram_we_q;
    assign cpu.cpu_rdata  = rdata;
    assign cpu.cpu_rvalid = rvalid_q;

endmodule

// File: tb/tb_dmg_cart_mbc1.sv
// Scoreboard testbench for dmg_cart_mbc1: directed cases followed by
// random bus traffic checked against a behavioural MBC1 model.
// Follows the DMG_CART_MBC1_RAM_EN build option of the design.
module tb_dmg_cart_mbc1;

    localparam int ROM_W = 15;
    localparam int RAM_W = 15;

`ifdef DMG_CART_MBC1_RAM_EN
    localparam bit RAM_ON = 1'b1;
`else
    localparam bit RAM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmg_cart_mbc1_if cpu_bus ();

    logic [ROM_W-1:0] rom_addr;
    logic [7:0]       rom_data = 8'h00;
    logic [RAM_W-1:0] ram_addr;
    logic [7:0]       ram_wdata;
    logic             ram_we;
    logic [7:0]       ram_data = 8'h00;

    dmg_cart_mbc1 #(.ROM_ADDR_W(ROM_W), .RAM_ADDR_W(RAM_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu_bus),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_data  (ram_data)
    );

    logic [7:0] rom_mem [0:(1<<ROM_W)-1];
    logic [7:0] ram_mem [0:(1<<RAM_W)-1];
    logic [7:0] ref_ram [0:(1<<RAM_W)-1];

    // Synchronous 1-cycle PROM and cart RAM models.
    always @(posedge clk) begin
        rom_data <= rom_mem[rom_addr];
        ram_data <= ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [7:0] data; int addr; } rd_exp_t;
    typedef struct { int due; bit is_rom; int addr; } ad_exp_t;
    typedef struct { int due; int addr; logic [7:0] data; } wr_exp_t;

    rd_exp_t rdq[$];
    ad_exp_t adq[$];
    wr_exp_t wrq[$];

    int checks = 0;
    int errors = 0;

    // Behavioural MBC1 state.
    int m_bank_lo, m_bank_hi, m_mode, m_ram_en;

    function automatic int rom_map(int a);
        int bank;
        if (a >= 'h4000) bank = m_bank_hi * 32 + m_bank_lo;
        else             bank = m_mode ? m_bank_hi * 32 : 0;
        return (bank * 16384 + a % 16384) % (1 << ROM_W);
    endfunction

    function automatic int ram_map(int a);
        return ((m_mode ? m_bank_hi * 8192 : 0) + a % 8192) % (1 << RAM_W);
    endfunction

    task automatic modelReset();
        m_bank_lo = 1;
        m_bank_hi = 0;
        m_mode    = 0;
        m_ram_en  = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Drive one bus cycle and record what the model expects from it.
    task automatic applyStimulus(input bit rd, input bit wr, input int addr, input int wdata);
        int n, ra;
        logic [7:0] exp_d;
        rd_exp_t r;
        ad_exp_t ad;
        wr_exp_t w;
        cpu_bus.cpu_rd    = rd;
        cpu_bus.cpu_wr    = wr;
        cpu_bus.cpu_addr  = addr[15:0];
        cpu_bus.cpu_wdata = wdata[7:0];
        n = cyc + 1;
        if (rd && !wr) begin
            if (addr < 'h8000) begin
                ra = rom_map(addr);
                exp_d = rom_mem[ra];
                ad.due = n; ad.is_rom = 1'b1; ad.addr = ra;
                adq.push_back(ad);
            end else if (addr >= 'hA000 && addr < 'hC000) begin
                ra = ram_map(addr);
                exp_d = (RAM_ON && m_ram_en != 0) ? ref_ram[ra] : 8'hFF;
                ad.due = n; ad.is_rom = 1'b0; ad.addr = RAM_ON ? ra : 0;
                adq.push_back(ad);
            end else begin
                exp_d = 8'hFF;
            end
            r.due = n + 1; r.data = exp_d; r.addr = addr;
            rdq.push_back(r);
        end
        if (wr) begin
            if (addr < 'h2000) begin
                m_ram_en = (wdata % 16 == 10) ? 1 : 0;
            end else if (addr < 'h4000) begin
                m_bank_lo = (wdata % 32 == 0) ? 1 : wdata % 32;
            end else if (addr < 'h6000) begin
                m_bank_hi = wdata % 4;
            end else if (addr < 'h8000) begin
                m_mode = wdata % 2;
            end else if (addr >= 'hA000 && addr < 'hC000 && RAM_ON && m_ram_en != 0) begin
                ra = ram_map(addr);
                ref_ram[ra] = 8'(wdata);
                w.due = n; w.addr = ra; w.data = 8'(wdata);
                wrq.push_back(w);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drop every expectation that the coming reset edge cancels.
    task automatic pruneFrom(input int n);
        for (int i = rdq.size() - 1; i >= 0; i--) if (rdq[i].due >= n) rdq.delete(i);
        for (int i = adq.size() - 1; i >= 0; i--) if (adq[i].due >= n) adq.delete(i);
        for (int i = wrq.size() - 1; i >= 0; i--) if (wrq[i].due >= n) wrq.delete(i);
    endtask

    // One reset cycle, optionally with a read request presented at the same edge.
    task automatic applyReset(input bit rd, input int addr);
        rst = 1'b0;
        cpu_bus.cpu_rd   = rd;
        cpu_bus.cpu_wr   = 1'b0;
        cpu_bus.cpu_addr = addr[15:0];
        pruneFrom(cyc + 1);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_bus.cpu_rd = 1'b0;
    endtask

    task automatic checkResetOutputs();
        checkOutput("reset_rom_addr", 32'(rom_addr), 0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 0);
        checkOutput("reset_ram_wdata", 32'(ram_wdata), 0);
        checkOutput("reset_ram_we", 32'(ram_we), 0);
        checkOutput("reset_cpu_rdata", 32'(cpu_bus.cpu_rdata), 32'hFF);
        checkOutput("reset_cpu_rvalid", 32'(cpu_bus.cpu_rvalid), 0);
    endtask

    // Monitor: compares registered addresses, read returns and RAM strobes against the queues.
    always @(negedge clk) begin
        while (adq.size() > 0 && adq[0].due <= cyc) begin
            ad_exp_t ad;
            ad = adq.pop_front();
            if (ad.is_rom) checkOutput("rom_addr", 32'(rom_addr), 32'(ad.addr));
            else           checkOutput("ram_addr", 32'(ram_addr), 32'(ad.addr));
        end
        while (rdq.size() > 0 && rdq[0].due < cyc) begin
            rd_exp_t r;
            r = rdq.pop_front();
            checks++; errors++;
            $display("[TB] FAIL missing_rvalid for read 0x%0h: got no pulse, expected one at cycle %0d", r.addr, r.due);
        end
        if (cpu_bus.cpu_rvalid === 1'b1) begin
            if (rdq.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_rvalid at cycle %0d: got pulse, expected none", cyc);
            end else begin
                rd_exp_t r;
                r = rdq.pop_front();
                checkOutput("rvalid_cycle", 32'(cyc), 32'(r.due));
                checkOutput("cpu_rdata", 32'(cpu_bus.cpu_rdata), 32'(r.data));
            end
        end
        while (wrq.size() > 0 && wrq[0].due < cyc) begin
            wr_exp_t w;
            w = wrq.pop_front();
            checks++; errors++;
            $display("[TB] FAIL missing_ram_we: got no strobe, expected one at cycle %0d", w.due);
        end
        if (ram_we === 1'b1) begin
            if (wrq.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_ram_we at cycle %0d: got strobe, expected none", cyc);
            end else begin
                wr_exp_t w;
                w = wrq.pop_front();
                checkOutput("ram_we_cycle", 32'(cyc), 32'(w.due));
                checkOutput("ram_we_addr", 32'(ram_addr), 32'(w.addr));
                checkOutput("ram_wdata", 32'(ram_wdata), 32'(w.data));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int op, a, d;
        for (int i = 0; i < (1 << ROM_W); i++) rom_mem[i] = 8'($urandom);
        for (int i = 0; i < (1 << RAM_W); i++) begin
            ram_mem[i] = 8'($urandom);
            ref_ram[i] = ram_mem[i];
        end
        cpu_bus.cpu_rd    = 1'b0;
        cpu_bus.cpu_wr    = 1'b0;
        cpu_bus.cpu_addr  = 16'h0000;
        cpu_bus.cpu_wdata = 8'h00;
        modelReset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        rst = 1'b1;

        $display("[TB] first banked read after reset");
        applyStimulus(1'b1, 1'b0, 'h4000, 0);
        idle(3);

        $display("[TB] zero-bank fix and ROM wrap");
        applyStimulus(1'b0, 1'b1, 'h2000, 'h00);
        applyStimulus(1'b1, 1'b0, 'h4123, 0);
        applyStimulus(1'b0, 1'b1, 'h2000, 'h03);
        applyStimulus(1'b1, 1'b0, 'h4123, 0);
        applyStimulus(1'b0, 1'b1, 'h2000, 'h20);
        applyStimulus(1'b1, 1'b0, 'h4000, 0);
        idle(3);

        $display("[TB] back-to-back reads and read+write collision");
        applyStimulus(1'b1, 1'b0, 'h0000, 0);
        applyStimulus(1'b1, 1'b0, 'h0001, 0);
        applyStimulus(1'b1, 1'b0, 'h0002, 0);
        applyStimulus(1'b1, 1'b1, 'h2000, 'h04);
        applyStimulus(1'b1, 1'b0, 'h4000, 0);
        idle(3);

        $display("[TB] cart RAM enable, write and disabled read");
        applyStimulus(1'b0, 1'b1, 'h0000, 'h0A);
        applyStimulus(1'b0, 1'b1, 'hA010, 'h5C);
        idle(1);
        applyStimulus(1'b1, 1'b0, 'hA010, 0);
        applyStimulus(1'b0, 1'b1, 'h0000, 'h00);
        applyStimulus(1'b1, 1'b0, 'hA010, 0);
        applyStimulus(1'b0, 1'b1, 'hA011, 'h77);
        idle(3);

        $display("[TB] RAM banking in mode 1");
        applyStimulus(1'b0, 1'b1, 'h6000, 'h01);
        applyStimulus(1'b0, 1'b1, 'h4000, 'h02);
        applyStimulus(1'b1, 1'b0, 'hA001, 0);
        applyStimulus(1'b0, 1'b1, 'h0000, 'h1A);
        applyStimulus(1'b0, 1'b1, 'hA001, 'hC3);
        applyStimulus(1'b1, 1'b0, 'hA001, 0);
        applyStimulus(1'b1, 1'b1, 'h4000, 'h01);
        applyStimulus(1'b1, 1'b0, 'h0100, 0);
        applyStimulus(1'b1, 1'b0, 'h9000, 0);
        idle(3);

        $display("[TB] reset with a read in flight");
        applyStimulus(1'b1, 1'b0, 'h4000, 0);
        applyReset(1'b0, 0);
        checkResetOutputs();
        idle(3);
        applyReset(1'b1, 'h4567);
        checkResetOutputs();
        idle(3);
        applyStimulus(1'b1, 1'b0, 'h4000, 0);
        applyStimulus(1'b1, 1'b0, 'hA000, 0);
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                applyStimulus(1'b0, 1'b0, 0, 0);
            end else if (op <= 5) begin
                case ($urandom_range(0, 3))
                    0: a = $urandom_range(0, 'h7FFF);
                    1: a = $urandom_range('hA000, 'hBFFF);
                    2: a = $urandom_range(0, 'hFFFF);
                    default: a = $urandom_range('h4000, 'h7FFF);
                endcase
                applyStimulus(1'b1, 1'b0, a, 0);
            end else if (op <= 7) begin
                a = $urandom_range(0, 'h7FFF);
                d = ($urandom_range(0, 3) == 0) ? 'h0A : $urandom_range(0, 255);
                applyStimulus(1'b0, 1'b1, a, d);
            end else if (op == 8) begin
                applyStimulus(1'b0, 1'b1, $urandom_range('hA000, 'hBFFF), $urandom_range(0, 255));
            end else begin
                a = $urandom_range(0, 'hFFFF);
                applyStimulus($urandom_range(0, 1) == 1, 1'b1, a, $urandom_range(0, 255));
            end
        end
        idle(5);

        checkOutput("read_queue_drained", 32'(rdq.size()), 0);
        checkOutput("ram_write_queue_drained", 32'(wrq.size()), 0);
        checkOutput("addr_queue_drained", 32'(adq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
